// File: rtl/bm_buf_reader.sv
// bm_buf_reader: read side of the block-matching BRAM ping-pong buffers.
// Watches the writer's frame counter. When a buffer set completes, it reads that
// buffer's three thirds in raster order through a credit-limited BRAM pipeline.
// The words are streamed out of a small show-ahead FIFO with a valid/ready handshake.
module bm_buf_reader #(
    parameter int unsigned third_cols     = 240,
    parameter int unsigned third_rows     = 480,
    parameter int unsigned num_pix        = 16,
    parameter int unsigned rd_latency     = 2,
    parameter int unsigned out_fifo_depth = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  image_number,
    output logic        bm_idle,
    output logic        bm_working_buf,
    output logic        rd_en,
    output logic [18:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic [15:0] pix_out,
    output logic [1:0]  pix_out_third,
    output logic        pix_out_sof,
    output logic        pix_out_eof,
    output logic        pix_out_valid,
    input  logic        pix_out_ready,
    output logic        overrun
);

    localparam int unsigned WR_COLS = third_cols / num_pix;
    localparam int unsigned WR_ROWS = third_rows;
    localparam int unsigned COL_W   = (WR_COLS > 1) ? $clog2(WR_COLS) : 1;
    localparam int unsigned ROW_W   = (WR_ROWS > 1) ? $clog2(WR_ROWS) : 1;
    localparam int unsigned CNT_W   = $clog2(out_fifo_depth + 1);
    localparam int unsigned PTR_W   = (out_fifo_depth > 1) ? $clog2(out_fifo_depth) : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WR_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(WR_ROWS - 1);
    localparam logic [CNT_W:0]   CREDIT    = (CNT_W + 1)'(out_fifo_depth);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(out_fifo_depth);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(out_fifo_depth - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

    state_t             state_q;
    logic               idle_q;
    logic               rd_buf_q;
    logic               overrun_q;
    logic [3:0]         seen_q;
    logic [3:0]         img_delta;

    logic [1:0]         third_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [15:0]        waddr_q;
    logic               col_last;
    logic               row_last;
    logic               sof_tag;
    logic               eof_tag;

    logic [CNT_W:0]     credit_used;
    logic               issue;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   in_flight_q;
    logic [CNT_W-1:0]   in_flight_d;
    logic [CNT_W-1:0]   fifo_cnt_q;
    logic [CNT_W-1:0]   fifo_cnt_d;

    logic [rd_latency-1:0]      vpipe_q;
    logic [rd_latency-1:0][3:0] tpipe_q;

    logic [19:0]        mem_q [out_fifo_depth];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Read issue, credit accounting and next-count arithmetic.
    always_comb begin
        img_delta   = image_number - seen_q;
        col_last    = (col_q == COL_LAST);
        row_last    = (row_q == ROW_LAST);
        sof_tag     = (waddr_q == '0);
        eof_tag     = col_last && row_last;
        credit_used = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
        issue       = (state_q == ST_READ) && (credit_used < CREDIT);
        push        = vpipe_q[rd_latency-1];
        pop         = (fifo_cnt_q != '0) && pix_out_ready;

        in_flight_d = in_flight_q;
        if (issue && !push) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (!issue && push) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end

        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end
    end

    // Frame detection, raster address walk and drain handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idle_q    <= 1'b1;
            rd_buf_q  <= 1'b0;
            overrun_q <= 1'b0;
            seen_q    <= '0;
            third_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            waddr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (img_delta != '0) begin
                        rd_buf_q <= ~image_number[0];
                        idle_q   <= 1'b0;
                        state_q  <= ST_READ;
                        if (img_delta > 4'd1) begin
                            overrun_q <= 1'b1;
                            seen_q    <= image_number;
                        end else begin
                            seen_q <= seen_q + 4'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                row_q   <= '0;
                                waddr_q <= '0;
                                if (third_q == 2'd2) begin
                                    third_q <= '0;
                                    state_q <= ST_DRAIN;
                                end else begin
                                    third_q <= third_q + 2'd1;
                                end
                            end else begin
                                row_q   <= row_q + ROW_W'(1);
                                waddr_q <= waddr_q + 16'd1;
                            end
                        end else begin
                            col_q   <= col_q + COL_W'(1);
                            waddr_q <= waddr_q + 16'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Looks at next-cycle counts so idle rises the cycle after the final transfer.
                    if ((in_flight_d == '0) && (fifo_cnt_d == '0)) begin
                        idle_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Delay line carrying read strobes and their tags to line up with rd_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe_q     <= '0;
            tpipe_q     <= '0;
            in_flight_q <= '0;
        end else begin
            vpipe_q[0] <= issue;
            tpipe_q[0] <= {third_q, sof_tag, eof_tag};
            for (int unsigned i = 1; i < rd_latency; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
                tpipe_q[i] <= tpipe_q[i-1];
            end
            in_flight_q <= in_flight_d;
        end
    end

    // Show-ahead output FIFO holding {third, sof, eof, data}.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < out_fifo_depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {tpipe_q[rd_latency-1], rd_data};
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // The credit rule must never let a push land on a full FIFO.
    assert property (@(posedge clk) disable iff (reset) !(push && !pop && (fifo_cnt_q == FIFO_FULL)));

    assign bm_idle        = idle_q;
    assign bm_working_buf = rd_buf_q;
    assign overrun        = overrun_q;
    assign rd_en          = issue;
    assign rd_addr        = {rd_buf_q, third_q, waddr_q};
    assign pix_out_valid  = (fifo_cnt_q != '0);
    assign pix_out        = mem_q[rd_ptr_q][15:0];
    assign pix_out_eof    = mem_q[rd_ptr_q][16];
    assign pix_out_sof    = mem_q[rd_ptr_q][17];
    assign pix_out_third  = mem_q[rd_ptr_q][19:18];

endmodule

// File: tb/tb_bm_buf_reader.sv
// Bench for bm_buf_reader: BRAM model returning the low 16 address bits, a
// scoreboard of expected read addresses and output words, and directed steps
// covering reset, full frames, backpressure, overrun and mid-frame reset.
module tb_bm_buf_reader;

    localparam int WORDS = 15 * 480;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  image_number;
    logic        bm_idle;
    logic        bm_working_buf;
    logic        rd_en;
    logic [18:0] rd_addr;
    logic [15:0] rd_data;
    logic [15:0] pix_out;
    logic [1:0]  pix_out_third;
    logic        pix_out_sof;
    logic        pix_out_eof;
    logic        pix_out_valid;
    logic        pix_out_ready;
    logic        overrun;

    bm_buf_reader dut (
        .clk            (clk),
        .reset          (reset),
        .image_number   (image_number),
        .bm_idle        (bm_idle),
        .bm_working_buf (bm_working_buf),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .pix_out        (pix_out),
        .pix_out_third  (pix_out_third),
        .pix_out_sof    (pix_out_sof),
        .pix_out_eof    (pix_out_eof),
        .pix_out_valid  (pix_out_valid),
        .pix_out_ready  (pix_out_ready),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // BRAM model: two-cycle read latency, data = low address bits.
    logic [18:0] b1, b2;
    always @(posedge clk) begin
        b1 <= rd_addr;
        b2 <= b1;
    end
    assign rd_data = b2[15:0];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [18:0] addr_q[$];
    logic [19:0] exp_q[$];
    logic        mon_on = 1'b0;
    logic        prev_stall = 1'b0;
    logic        idle_chk = 1'b0;
    logic [19:0] prev_word = '0;
    int          outstanding = 0;
    int          xfer_cnt = 0;
    int          rdy_mode = 0;
    wire  [19:0] cur_word = {pix_out_third, pix_out_sof, pix_out_eof, pix_out};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input logic b);
        logic [15:0] w16;
        logic [1:0]  t2;
        for (int t = 0; t < 3; t++) begin
            for (int w = 0; w < WORDS; w++) begin
                w16 = 16'(w);
                t2  = 2'(t);
                addr_q.push_back({b, t2, w16});
                exp_q.push_back({t2, (w == 0), (w == WORDS - 1), w16});
            end
        end
    endtask

    task automatic start_frame(input logic [3:0] img, input logic b, input logic exp_ovr);
        load_frame(b);
        xfer_cnt = 0;
        mon_on   = 1'b1;
        @(negedge clk); #1;
        image_number = img;
        @(negedge clk);
        check("bm_idle_start", 32'(bm_idle), 32'd0);
        check("working_buf", 32'(bm_working_buf), 32'(b));
        check("overrun_start", 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic wait_frame(input int budget, input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        check("reads_done", 32'(addr_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Ready driver: 0 = always high, 1 = held low, 2 = random (mostly high).
    initial begin
        pix_out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       pix_out_ready = 1'b1;
                1:       pix_out_ready = 1'b0;
                default: pix_out_ready = ($urandom_range(0, 7) != 0);
            endcase
        end
    end

    // Monitor: reads and transfers popped from the scoreboard.
    always @(negedge clk) begin
        if (!mon_on) begin
            prev_stall = 1'b0;
            idle_chk   = 1'b0;
        end else begin
            if (idle_chk) begin
                check("idle_after_last", 32'(bm_idle), 32'd1);
                check("valid_after_last", 32'(pix_out_valid), 32'd0);
                idle_chk = 1'b0;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(pix_out_valid), 32'd1);
                check("stall_hold", 32'(cur_word), 32'(prev_word));
            end
            if (rd_en) begin
                check("read_expected", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) check("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
                check("credit", 32'(outstanding < DEPTH), 32'd1);
                outstanding++;
            end
            if (pix_out_valid && pix_out_ready) begin
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("word", 32'(cur_word), 32'(exp_q.pop_front()));
                    if (exp_q.size() == 0) idle_chk = 1'b1;
                end
                xfer_cnt++;
                outstanding--;
            end
            prev_stall = pix_out_valid && !pix_out_ready;
            prev_word  = cur_word;
        end
    end

    initial begin
        int k;
        reset        = 1'b1;
        image_number = 4'd0;

        // Reset state, then idle with image_number unchanged.
        repeat (3) @(negedge clk);
        check("rst_idle", 32'(bm_idle), 32'd1);
        check("rst_valid", 32'(pix_out_valid), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_pix_out", 32'(pix_out), 32'd0);
        reset  = 1'b0;
        mon_on = 1'b1;
        repeat (100) @(negedge clk);
        check("hold_idle", 32'(bm_idle), 32'd1);
        check("hold_valid", 32'(pix_out_valid), 32'd0);
        check("hold_rd_en", 32'(rd_en), 32'd0);
        check("hold_overrun", 32'(overrun), 32'd0);

        // Frame 0->1, buffer 0, ready held high.
        start_frame(4'd1, 1'b0, 1'b0);
        wait_frame(25000, "frame1_done");

        // Frame 1->2, buffer 1, 100 stalled cycles then random backpressure.
        rdy_mode = 1;
        start_frame(4'd2, 1'b1, 1'b0);
        repeat (100) @(negedge clk);
        check("stall_no_xfer", 32'(xfer_cnt), 32'd0);
        check("credit_full", 32'(outstanding), 32'(DEPTH));
        rdy_mode = 2;
        wait_frame(60000, "frame2_done");
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        // Jump 2->4 while idle: overrun, exactly one frame from buffer 1.
        start_frame(4'd4, 1'b1, 1'b1);
        wait_frame(25000, "frame3_done");
        repeat (50) @(negedge clk);
        check("single_frame_idle", 32'(bm_idle), 32'd1);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Frame 4->5 cut by reset at word 5000.
        start_frame(4'd5, 1'b0, 1'b1);
        k = 0;
        while (xfer_cnt < 5000 && k < 8000) begin
            @(negedge clk); #1;
            k++;
        end
        check("reach_5000", 32'(xfer_cnt >= 5000), 32'd1);
        mon_on = 1'b0;
        reset  = 1'b1;
        #1;
        check("mid_rst_idle", 32'(bm_idle), 32'd1);
        check("mid_rst_valid", 32'(pix_out_valid), 32'd0);
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        check("mid_rst_pix_out", 32'(pix_out), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        check("mid_rst_wbuf", 32'(bm_working_buf), 32'd0);
        image_number = 4'd0;
        addr_q.delete();
        exp_q.delete();
        outstanding = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_rd_en", 32'(rd_en), 32'd0);
        end
        reset  = 1'b0;
        mon_on = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 32'(bm_idle), 32'd1);

        // Restart after reset begins at third 0, word 0 of buffer 0.
        start_frame(4'd1, 1'b0, 1'b0);
        k = 0;
        while (xfer_cnt < 300 && k < 1000) begin
            @(negedge clk); #1;
            k++;
        end
        check("restart_progress", 32'(xfer_cnt >= 300), 32'd1);
        mon_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
